meter_time_ctrl: RTL and testbench

//  Parking-meter time controller. Holds remaining time as 4-digit packed BCD seconds (0000-9999)
//  and applies coin-add and preset commands. Counts the value down once per second from an

---
 rtl/meter_time_ctrl_if.sv | 31 +++
 rtl/meter_time_ctrl.sv | 133 +++++++++++++
 tb/tb_meter_time_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/meter_time_ctrl_if.sv
// meter_time_ctrl_if
//   Groups the button inputs and the time/status outputs of the parking-meter
//   time controller.
//   master : button source (drives btn_*, observes time and flags)
//   slave  : the time controller itself
//   btn_add[3:0]    one-cycle add pulses (+60/+120/+180/+300 s)
//   btn_preset[1:0] one-cycle preset pulses ([0] load 0015, [1] load 0150)
//   bcd_time[15:0]  remaining seconds, packed BCD
//   clk_HalfHz      0.5 Hz blink clock
//   sec_tick        one-cycle pulse per second
//   expired         time is 0000
//   low_time        0000 < time <= 0180
interface meter_time_ctrl_if;
  logic [3:0]  btn_add;
  logic [1:0]  btn_preset;
  logic [15:0] bcd_time;
  logic        clk_HalfHz;
  logic        sec_tick;
  logic        expired;
  logic        low_time;

  modport master (
    output btn_add, btn_preset,
    input  bcd_time, clk_HalfHz, sec_tick, expired, low_time
  );

  modport slave (
    input  btn_add, btn_preset,
    output bcd_time, clk_HalfHz, sec_tick, expired, low_time
  );
endinterface

// File: rtl/meter_time_ctrl.sv
// meter_time_ctrl
//   Parking-meter time controller. Keeps remaining time as 4-digit packed BCD
//   seconds, applies coin adds and presets, counts down once per second from
//   an internal prescaler and produces the blink clock and status flags.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : meter_time_ctrl_if.slave (buttons in, time/flags out)
//
//   state    | meaning
//   ---------+--------------------------------------------
//   EXPIRED  | bcd_time == 0000, tick does not decrement
//   RUNNING  | bcd_time != 0000, each tick decrements by 1
module meter_time_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  meter_time_ctrl_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {EXPIRED = 1'b0, RUNNING = 1'b1} state_t;

  state_t        r_state;
  logic [15:0]   r_bcd;
  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic          r_half;

  logic [15:0]   w_amt;
  logic [16:0]   w_sum_raw;
  logic [15:0]   w_sum;
  logic [15:0]   w_sum_dec;
  logic [15:0]   w_dec;
  logic          w_presc_last;

  // Digit-serial decimal add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  // Decimal decrement by one; callers only use it on nonzero values.
  function automatic logic [15:0] bcd_dec(input logic [15:0] a);
    logic [15:0] r;
    logic        b;
    r = a;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (a[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = a[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Highest-index add button wins.
  always_comb begin
    w_amt = 16'h0000;
    if (bus.btn_add[3])      w_amt = 16'h0300;
    else if (bus.btn_add[2]) w_amt = 16'h0180;
    else if (bus.btn_add[1]) w_amt = 16'h0120;
    else if (bus.btn_add[0]) w_amt = 16'h0060;
  end

  assign w_sum_raw = bcd_add(r_bcd, w_amt);
  assign w_sum     = w_sum_raw[16] ? 16'h9999 : w_sum_raw[15:0];
  assign w_sum_dec = bcd_dec(w_sum);
  assign w_dec     = bcd_dec(r_bcd);

  assign w_presc_last = (r_presc == PRESC_LAST);

  // Free-running prescaler; never disturbed by buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_half     <= 1'b0;
    end else begin
      r_presc    <= w_presc_last ? '0 : r_presc + PW'(1);
      r_sec_tick <= w_presc_last;
      r_half     <= r_half ^ w_presc_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EXPIRED;
      r_bcd   <= 16'h0000;
    end else begin
      if (|bus.btn_preset) begin
        r_bcd   <= bus.btn_preset[0] ? 16'h0015 : 16'h0150;
        r_state <= RUNNING;
      end else if (|bus.btn_add) begin
        // Sum is at least 60, so taking a coincident tick never reaches zero.
        r_bcd   <= r_sec_tick ? w_sum_dec : w_sum;
        r_state <= RUNNING;
      end else if (r_sec_tick && (r_state == RUNNING)) begin
        r_bcd <= w_dec;
        if (w_dec == 16'h0000) r_state <= EXPIRED;
      end
    end
  end

  // BCD ordering matches numeric ordering, so direct compares are valid.
  assign bus.bcd_time   = r_bcd;
  assign bus.clk_HalfHz = r_half;
  assign bus.sec_tick   = r_sec_tick;
  assign bus.expired    = (r_bcd == 16'h0000);
  assign bus.low_time   = (r_bcd != 16'h0000) && (r_bcd <= 16'h0180);

endmodule

// File: tb/tb_meter_time_ctrl.sv
module tb_meter_time_ctrl;

  localparam int TDIV = 4;

  logic clk;
  logic rst_n;
  meter_time_ctrl_if bus ();

  meter_time_ctrl #(.TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit tick;
    bit half;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state (seconds as a plain integer)
  int m_val;
  int m_presc;
  bit m_tick;
  bit m_half;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val   = 0;
      m_presc = 0;
      m_tick  = 0;
      m_half  = 0;
      q.delete();
    end else begin
      int amt;
      bit tick_now;
      exp_t e;
      tick_now = m_tick;
      amt = bus.btn_add[3] ? 300 : bus.btn_add[2] ? 180 :
            bus.btn_add[1] ? 120 : bus.btn_add[0] ? 60 : 0;
      if (bus.btn_preset[0])      m_val = 15;
      else if (bus.btn_preset[1]) m_val = 150;
      else if (amt != 0) begin
        m_val = m_val + amt;
        if (m_val > 9999) m_val = 9999;
        if (tick_now) m_val = m_val - 1;
      end else if (tick_now && m_val > 0) m_val = m_val - 1;
      m_tick  = (m_presc == TDIV - 1);
      m_half  = m_half ^ m_tick;
      m_presc = (m_presc + 1) % TDIV;
      e.val = m_val; e.tick = m_tick; e.half = m_half;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("bcd_time",   int'(bus.bcd_time),   int'(to_bcd(e.val)));
      chk("expired",    int'(bus.expired),    int'(e.val == 0));
      chk("low_time",   int'(bus.low_time),   int'(e.val > 0 && e.val <= 180));
      chk("sec_tick",   int'(bus.sec_tick),   int'(e.tick));
      chk("clk_HalfHz", int'(bus.clk_HalfHz), int'(e.half));
    end
  end

  // Inputs change 1 time unit after a rising edge and are held for one cycle.
  task automatic step(input logic [3:0] a, input logic [1:0] p);
    bus.btn_add    = a;
    bus.btn_preset = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 2'b00);
  endtask

  initial begin
    bus.btn_add    = 4'b0000;
    bus.btn_preset = 2'b00;
    rst_n = 1'b0;
    #12;
    chk("rst_bcd", int'(bus.bcd_time), 0);
    chk("rst_expired", int'(bus.expired), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // +60 from zero, count all the way down and linger at zero
    step(4'b0001, 2'b00);
    idle(300);

    // presets, including both bits at once
    step(4'b0010, 2'b00);
    idle(5);
    step(4'b0000, 2'b10);
    idle(3);
    step(4'b0000, 2'b11);
    idle(80);

    // saturation
    for (int i = 0; i < 36; i++) step(4'b1000, 2'b00);
    step(4'b0001, 2'b00);
    step(4'b0001, 2'b00);
    idle(10);
    step(4'b0000, 2'b10);

    // climb above 180 then count down through the low_time boundary to zero
    step(4'b0100, 2'b00);
    idle(1500);

    // simultaneous add buttons from zero
    step(4'b0011, 2'b00);
    idle(8);
    step(4'b0000, 2'b01);
    idle(70);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      logic [1:0] p;
      a = 4'b0000;
      p = 2'b00;
      if ($urandom_range(0, 99) < 3) a = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 199) < 1) p = 2'($urandom_range(1, 3));
      step(a, p);
    end

    // async reset while running with a tick in flight
    step(4'b0010, 2'b00);
    idle(10);
    for (int i = 0; i < 8 && !m_tick; i++) idle(1);
    chk("pre_rst_tick", int'(bus.sec_tick), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd",     int'(bus.bcd_time),   0);
    chk("arst_expired", int'(bus.expired),    1);
    chk("arst_low",     int'(bus.low_time),   0);
    chk("arst_tick",    int'(bus.sec_tick),   0);
    chk("arst_half",    int'(bus.clk_HalfHz), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(20);
    step(4'b0001, 2'b00);
    idle(10);

    chk("queue_drained", int'(q.size() <= 1), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
